back_vram_arbiter: RTL and testbench

BACK_VRAM_ARBITER -- requirements
Module: back_vram_arbiter

---
 rtl/vram_pkg.sv | 17 +
 rtl/strobe_timer.sv | 15 +
 rtl/back_vram_arbiter.sv | 88 ++++++++
 tb/tb_back_vram_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// vram_pkg: shared widths, timing defaults and FSM encoding for the back VRAM arbiter
package vram_pkg;
  localparam int VRAM_AW = 13;
  localparam int VRAM_DW = 8;
  localparam int DEF_ACCESS_CYCLES = 2;
  localparam int DEF_MAX_BURST = 8;
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_PULSE = 3'd1;
  localparam logic [2:0] RD_DONE  = 3'd2;
  localparam logic [2:0] WR_SETUP = 3'd3;
  localparam logic [2:0] WR_PULSE = 3'd4;
  localparam logic [2:0] WR_HOLD  = 3'd5;
  typedef enum logic {OWN_CPY = 1'b0, OWN_CPU = 1'b1} owner_t;
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction
endpackage

// File: rtl/strobe_timer.sv
// strobe_timer: down-counter timing the SRAM strobe width; done marks the last strobe cycle
module strobe_timer (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       done
);
  logic [3:0] cnt;
  always_ff @(posedge clk)
    if (!clr_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != 4'd0) cnt <= cnt - 4'd1;
  assign done = cnt == 4'd1;
endmodule

// File: rtl/back_vram_arbiter.sv
// back_vram_arbiter: shares the back VRAM SRAM between the CPU and the buffer copier
module back_vram_arbiter
  import vram_pkg::*;
#(
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
  parameter int MAX_BURST     = DEF_MAX_BURST
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [VRAM_AW-1:0]  cpu_addr,
  input  logic [VRAM_DW-1:0]  cpu_wdata,
  output logic                cpu_ack,
  output logic [VRAM_DW-1:0]  cpu_rdata,
  input  logic                cpy_req,
  input  logic [VRAM_AW-1:0]  cpy_addr,
  output logic                cpy_ack,
  output logic [VRAM_DW-1:0]  cpy_rdata,
  output logic [VRAM_AW-1:0]  vram_addr,
  output logic [VRAM_DW-1:0]  vram_dout,
  output logic                vram_dout_oe,
  input  logic [VRAM_DW-1:0]  vram_din,
  output logic                vram_rd_low,
  output logic                vram_wr_low,
  output logic                busy
);
  localparam logic [7:0] MB = 8'(MAX_BURST);
  localparam logic [3:0] AC = 4'(ACCESS_CYCLES);
  logic [2:0] state;
  logic [7:0] burst_cnt;
  owner_t     owner;
  logic       grant_cpy, grant_cpu, load, done;
  // the copier wins ties until its burst allowance is spent, so the CPU is never starved
  always_comb begin
    grant_cpy = state == IDLE && cpy_req && !(cpu_req && burst_cnt == MB);
    grant_cpu = state == IDLE && cpu_req && !grant_cpy;
    load      = grant_cpy || (grant_cpu && !cpu_we) || state == WR_SETUP;
  end
  strobe_timer u_timer (
    .clk      (clk),
    .clr_n    (rst_n),
    .load     (load),
    .load_val (AC),
    .done     (done)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
      owner     <= OWN_CPY;
      vram_addr <= '0;
      vram_dout <= '0;
      cpu_rdata <= '0;
      cpy_rdata <= '0;
    end else begin
      case (state)
        IDLE:
          if (grant_cpy) begin
            state     <= RD_PULSE;
            owner     <= OWN_CPY;
            vram_addr <= cpy_addr;
            burst_cnt <= sat_inc(burst_cnt, MB);
          end else if (grant_cpu) begin
            state     <= cpu_we ? WR_SETUP : RD_PULSE;
            owner     <= OWN_CPU;
            vram_addr <= cpu_addr;
            burst_cnt <= '0;
            if (cpu_we) vram_dout <= cpu_wdata;
          end else if (!cpy_req) burst_cnt <= '0;
        RD_PULSE:
          if (done) begin
            state <= RD_DONE;
            if (owner == OWN_CPU) cpu_rdata <= vram_din;
            else cpy_rdata <= vram_din;
          end
        WR_SETUP: state <= WR_PULSE;
        WR_PULSE: if (done) state <= WR_HOLD;
        default:  state <= IDLE;
      endcase
    end
  assign busy         = state != IDLE;
  assign vram_rd_low  = state != RD_PULSE;
  assign vram_wr_low  = state != WR_PULSE;
  assign vram_dout_oe = state == WR_SETUP || state == WR_PULSE || state == WR_HOLD;
  assign cpu_ack      = state == WR_HOLD || (state == RD_DONE && owner == OWN_CPU);
  assign cpy_ack      = state == RD_DONE && owner == OWN_CPY;
endmodule

// File: tb/tb_back_vram_arbiter.sv
// tb_back_vram_arbiter: directed scoreboard bench with an SRAM model and protocol monitor
module tb_back_vram_arbiter;
  localparam int AC = 2;
  localparam int MB = 8;
  logic        clk = 0, rst_n = 0;
  logic        cpu_req = 0, cpu_we = 0, cpy_req = 0;
  logic [12:0] cpu_addr = 0, cpy_addr = 0, vram_addr;
  logic [7:0]  cpu_wdata = 0, cpu_rdata, cpy_rdata, vram_dout, vram_din;
  logic        cpu_ack, cpy_ack, vram_dout_oe, vram_rd_low, vram_wr_low, busy;
  int          tests = 0, fails = 0;
  logic [7:0]  mem [8192];
  logic        wrote [8192];
  logic [7:0]  ref_mem [int];
  typedef struct {logic wr; logic [12:0] addr; logic [7:0] data;} exp_t;
  exp_t        cpu_q [$];
  exp_t        cpy_q [$];
  logic        ack_log [$];
  logic        log_on = 0;

  always #10 clk = ~clk;

  back_vram_arbiter #(.ACCESS_CYCLES(AC), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpy_req(cpy_req), .cpy_addr(cpy_addr), .cpy_ack(cpy_ack), .cpy_rdata(cpy_rdata),
    .vram_addr(vram_addr), .vram_dout(vram_dout), .vram_dout_oe(vram_dout_oe),
    .vram_din(vram_din), .vram_rd_low(vram_rd_low), .vram_wr_low(vram_wr_low), .busy(busy)
  );

  function automatic logic [7:0] init_val(input logic [12:0] a);
    return (a == 13'h0010) ? 8'hC3 : (a[7:0] ^ 8'h5C ^ {3'b0, a[12:8]});
  endfunction

  function automatic logic [7:0] ref_rd(input logic [12:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  // SRAM model: written by the strobes, read asynchronously
  always @(posedge clk)
    if (!vram_wr_low) begin
      mem[vram_addr]   <= vram_dout;
      wrote[vram_addr] <= 1'b1;
    end
  always_comb vram_din = (wrote[vram_addr] === 1'b1) ? mem[vram_addr] : init_val(vram_addr);

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic pca = 0, pya = 0;
    int   oe_run = 0, wr_run = 0, rd_run = 0;
    forever begin
      @(negedge clk);
      chk("strobe_overlap", int'(!vram_rd_low && !vram_wr_low), 0);
      chk("oe_during_read", int'(vram_dout_oe && !vram_rd_low), 0);
      chk("ack_single_cycle", int'((cpu_ack && pca) || (cpy_ack && pya)), 0);
      chk("ack_both", int'(cpu_ack && cpy_ack), 0);
      if (cpu_ack) begin
        chk("cpu_ack_expected", int'(cpu_q.size() != 0), 1);
        if (cpu_q.size() != 0) begin
          e = cpu_q.pop_front();
          if (e.wr) chk("cpu_write_mem", int'(mem[e.addr]), int'(e.data));
          else chk("cpu_rdata", int'(cpu_rdata), int'(e.data));
        end
        if (log_on) ack_log.push_back(1'b1);
      end
      if (cpy_ack) begin
        chk("cpy_ack_expected", int'(cpy_q.size() != 0), 1);
        if (cpy_q.size() != 0) begin
          e = cpy_q.pop_front();
          chk("cpy_rdata", int'(cpy_rdata), int'(e.data));
        end
        if (log_on) ack_log.push_back(1'b0);
      end
      pca = cpu_ack;
      pya = cpy_ack;
      if (vram_dout_oe) oe_run++;
      else begin
        if (oe_run != 0 && rst_n) chk("oe_width", oe_run, AC + 2);
        oe_run = 0;
      end
      if (!vram_wr_low) wr_run++;
      else begin
        if (wr_run != 0 && rst_n) chk("wr_low_width", wr_run, AC);
        wr_run = 0;
      end
      if (!vram_rd_low) rd_run++;
      else begin
        if (rd_run != 0 && rst_n) chk("rd_low_width", rd_run, AC);
        rd_run = 0;
      end
    end
  endtask

  task automatic cpu_access(input logic we, input logic [12:0] a, input logic [7:0] d, output int lat);
    exp_t e;
    e.wr = we;
    e.addr = a;
    e.data = we ? d : ref_rd(a);
    if (we) ref_mem[int'(a)] = d;
    cpu_q.push_back(e);
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
    cpu_req = 1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!cpu_ack && lat < 200);
    chk("cpu_ack_before_timeout", int'(cpu_ack), 1);
    @(posedge clk);
    #1;
    cpu_req = 0;
  endtask

  task automatic cpy_read(input logic [12:0] a, output int lat);
    exp_t e;
    e.wr = 0;
    e.addr = a;
    e.data = ref_rd(a);
    cpy_q.push_back(e);
    cpy_addr = a;
    cpy_req = 1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!cpy_ack && lat < 200);
    chk("cpy_ack_before_timeout", int'(cpy_ack), 1);
    @(posedge clk);
    #1;
    cpy_req = 0;
  endtask

  task automatic gap();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_low", int'(vram_rd_low), 1);
    chk("rst_wr_low", int'(vram_wr_low), 1);
    chk("rst_oe", int'(vram_dout_oe), 0);
    chk("rst_acks", int'({cpu_ack, cpy_ack}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_addr_dout", int'({vram_addr, vram_dout}), 0);
    chk("rst_rdata", int'({cpu_rdata, cpy_rdata}), 0);
    rst_n = 1;
    fork monitor(); join_none
    gap();
    cpu_access(1, 13'h1ABC, 8'h5A, lat);
    chk("wr_latency", lat, AC + 2);
    chk("wr_mem_1abc", int'(mem[13'h1ABC]), 8'h5A);
    gap();
    cpy_read(13'h0010, lat);
    chk("rd_latency", lat, AC + 1);
    chk("cpy_rdata_c3", int'(cpy_rdata), 8'hC3);
    gap();
    cpu_access(0, 13'h1ABC, 8'h00, lat);
    chk("cpu_rd_latency", lat, AC + 1);
    gap();
    for (int i = 0; i < 3; i++) cpu_access(1'(i & 1), 13'h0050 + 13'(i), 8'hA0 + 8'(i), lat);
    for (int i = 0; i < 3; i++) cpy_read(13'h0060 + 13'(i), lat);
    gap();
    ack_log.delete();
    log_on = 1;
    fork
      for (int i = 0; i < 16; i++) cpy_read(13'h0100 + 13'(i), lat);
      begin
        int l2;
        for (int i = 0; i < 2; i++) cpu_access(0, 13'h0200 + 13'(i), 8'h00, l2);
      end
    join
    log_on = 0;
    chk("burst_ack_count", ack_log.size(), 18);
    for (int i = 0; i < 18 && i < ack_log.size(); i++)
      chk($sformatf("burst_owner_%0d", i), int'(ack_log[i]), int'(i == 8 || i == 17));
    gap();
    cpu_we = 1;
    cpu_addr = 13'h0777;
    cpu_wdata = 8'hEE;
    cpu_req = 1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (vram_wr_low && n < 50);
    chk("abort_reached_pulse", int'(vram_wr_low), 0);
    @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk);
    #1;
    chk("abort_wr_low", int'(vram_wr_low), 1);
    chk("abort_oe", int'(vram_dout_oe), 0);
    chk("abort_cpu_ack", int'(cpu_ack), 0);
    chk("abort_busy", int'(busy), 0);
    cpu_req = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    gap();
    cpu_access(1, 13'h0777, 8'hEE, lat);
    chk("reissue_wr_latency", lat, AC + 2);
    gap();
    cpu_access(0, 13'h0777, 8'h00, lat);
    gap();
    fork
      begin
        int l3;
        for (int i = 0; i < 4; i++) cpu_access(1, 13'h0300 + 13'(i), 8'h10 * 8'(i) + 8'h7, l3);
        for (int i = 0; i < 4; i++) cpu_access(0, 13'h0300 + 13'(i), 8'h00, l3);
      end
      for (int i = 0; i < 8; i++) cpy_read(13'h0400 + 13'(3 * i), lat);
    join
    gap();
    gap();
    chk("cpu_queue_drained", cpu_q.size(), 0);
    chk("cpy_queue_drained", cpy_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
